main_memory_responder: RTL

- Backing-store model and responder for the data-cache miss path.
- Serves the block-level requests the cache controller issues: a write-back pulse (i_WriteEnableMainMemory) and an allocate pulse (i_ReadEnable).
- After a programmable latency it commits or returns one cache line and pulses o_MemReady for one cycle.
- Sits between the cache controller/cache data array and the top-level processor memory map.

---
 rtl/main_memory_responder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/main_memory_responder.sv
// Line-granular backing store for the data-cache miss path: services write-back and
// allocate pulses after LATENCY cycles. Define MEM_CLEAR_ON_RESET_EN to zero the array after reset.
module main_memory_responder #(
   parameter int BUS_WIDTH     = 32,
   parameter int Address_WIDTH = 10,
   parameter int OFFSET_BITS   = 2,
   parameter int LATENCY       = 4
) (
   input  logic                                    i_clk,
   input  logic                                    i_reset,
   input  logic                                    i_ReadEnable,
   input  logic                                    i_WriteEnableMainMemory,
   input  logic [Address_WIDTH-1:0]                i_Address,
   input  logic [BUS_WIDTH*(1<<OFFSET_BITS)-1:0]   i_WriteBlock,
   output logic [BUS_WIDTH*(1<<OFFSET_BITS)-1:0]   o_ReadBlock,
   output logic                                    o_MemReady,
   output logic                                    o_Busy
);
   localparam int BLOCK_WORDS = 1 << OFFSET_BITS;
   localparam int LINE_W      = BUS_WIDTH * BLOCK_WORDS;
   localparam int LINE_BITS   = Address_WIDTH - OFFSET_BITS;
   localparam int DEPTH       = 1 << LINE_BITS;
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

`ifdef MEM_CLEAR_ON_RESET_EN
   typedef enum logic [1:0] {S_IDLE, S_WRITE_WAIT, S_READ_WAIT, S_CLEAR} state_t;
   localparam logic [LINE_BITS-1:0] LAST_LINE = '1;
   logic                 clr_go;
   logic [LINE_BITS-1:0] clr_idx;
`else
   typedef enum logic [1:0] {S_IDLE, S_WRITE_WAIT, S_READ_WAIT} state_t;
`endif

   logic [LINE_W-1:0] mem [DEPTH];

   state_t               state, nxt_state;
   logic [3:0]           cnt, nxt_cnt;
   logic [LINE_BITS-1:0] act_line, nxt_act_line;
   logic [LINE_W-1:0]    act_data, nxt_act_data;
   logic                 pw_vld, nxt_pw_vld, pr_vld, nxt_pr_vld;
   logic [LINE_BITS-1:0] pw_line, nxt_pw_line, pr_line, nxt_pr_line;
   logic [LINE_W-1:0]    pw_data, nxt_pw_data;
   logic                 done, free, commit, ld_rd;
   logic                 take_pw, take_pr, take_w, take_r;
   logic [LINE_W-1:0]    rd_data;
   logic [LINE_BITS-1:0] line_in;
   logic                 unused_offset;

   assign line_in       = i_Address[Address_WIDTH-1:OFFSET_BITS];
   assign unused_offset = ^i_Address[OFFSET_BITS-1:0];

   assign done   = (state == S_WRITE_WAIT || state == S_READ_WAIT) && cnt == 4'd0;
   assign commit = done && state == S_WRITE_WAIT;
`ifdef MEM_CLEAR_ON_RESET_EN
   assign free = done || (state == S_IDLE && !clr_go) || (state == S_CLEAR && clr_idx == LAST_LINE);
`else
   assign free = done || state == S_IDLE;
`endif

   always_comb begin
      nxt_state    = state;
      nxt_cnt      = cnt;
      nxt_act_line = act_line;
      nxt_act_data = act_data;
      nxt_pw_vld   = pw_vld;
      nxt_pw_line  = pw_line;
      nxt_pw_data  = pw_data;
      nxt_pr_vld   = pr_vld;
      nxt_pr_line  = pr_line;
      take_pw      = 1'b0;
      take_pr      = 1'b0;
      take_w       = 1'b0;
      take_r       = 1'b0;
      if ((state == S_WRITE_WAIT || state == S_READ_WAIT) && cnt != 4'd0)
         nxt_cnt = cnt - 4'd1;
      // Service order when a slot frees up: pending write, pending read, then new pulses.
      if (free) begin
         if (pw_vld)                       take_pw = 1'b1;
         else if (pr_vld)                  take_pr = 1'b1;
         else if (i_WriteEnableMainMemory) take_w  = 1'b1;
         else if (i_ReadEnable)            take_r  = 1'b1;
      end
      if (take_pw) nxt_pw_vld = 1'b0;
      if (take_pr) nxt_pr_vld = 1'b0;
      if (i_WriteEnableMainMemory && !take_w) begin
         nxt_pw_vld  = 1'b1;
         nxt_pw_line = line_in;
         nxt_pw_data = i_WriteBlock;
      end
      if (i_ReadEnable && !take_r) begin
         nxt_pr_vld  = 1'b1;
         nxt_pr_line = line_in;
      end
      if (take_pw || take_w) begin
         nxt_state    = S_WRITE_WAIT;
         nxt_cnt      = CNT_LOAD;
         nxt_act_line = take_pw ? pw_line : line_in;
         nxt_act_data = take_pw ? pw_data : i_WriteBlock;
      end else if (take_pr || take_r) begin
         nxt_state    = S_READ_WAIT;
         nxt_cnt      = CNT_LOAD;
         nxt_act_line = take_pr ? pr_line : line_in;
      end else if (free) begin
         nxt_state = S_IDLE;
      end
`ifdef MEM_CLEAR_ON_RESET_EN
      if (state == S_IDLE && clr_go)
         nxt_state = S_CLEAR;
`endif
   end

   // Read data is captured on entry to the ready cycle so it is valid alongside o_MemReady;
   // a write committing on that same edge is forwarded.
   assign ld_rd = nxt_state == S_READ_WAIT && nxt_cnt == 4'd0;

   always_comb begin
      rd_data = mem[nxt_act_line];
      if (commit && act_line == nxt_act_line)
         rd_data = act_data;
`ifdef MEM_CLEAR_ON_RESET_EN
      if (state == S_CLEAR && clr_idx == nxt_act_line)
         rd_data = '0;
`endif
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         act_line    <= '0;
         act_data    <= '0;
         pw_vld      <= 1'b0;
         pw_line     <= '0;
         pw_data     <= '0;
         pr_vld      <= 1'b0;
         pr_line     <= '0;
         o_ReadBlock <= '0;
      end else begin
         state    <= nxt_state;
         cnt      <= nxt_cnt;
         act_line <= nxt_act_line;
         act_data <= nxt_act_data;
         pw_vld   <= nxt_pw_vld;
         pw_line  <= nxt_pw_line;
         pw_data  <= nxt_pw_data;
         pr_vld   <= nxt_pr_vld;
         pr_line  <= nxt_pr_line;
         if (ld_rd)
            o_ReadBlock <= rd_data;
      end
   end

`ifdef MEM_CLEAR_ON_RESET_EN
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         clr_go  <= 1'b1;
         clr_idx <= '0;
      end else begin
         clr_go <= 1'b0;
         if (state == S_CLEAR)
            clr_idx <= clr_idx + 1'b1;
      end
   end
`endif

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         if (commit)
            mem[act_line] <= act_data;
`ifdef MEM_CLEAR_ON_RESET_EN
         if (state == S_CLEAR)
            mem[clr_idx] <= '0;
`endif
      end
   end

   assign o_MemReady = done;
   assign o_Busy     = state != S_IDLE || pw_vld || pr_vld;

endmodule
